// File: rtl/ads1115_pkg.sv
// Shared constants and types for the ADS1115 I2C target and its bus partner.
// Defaults match an ADS1115 with its ADDR pin tied to GND.
package ads1115_pkg;

    localparam logic [6:0]  DEV_ADDR_DEFAULT  = 7'h48;
    localparam logic [15:0] CFG_RESET_DEFAULT = 16'h8583;
    localparam logic [15:0] LO_RESET_DEFAULT  = 16'h8000;
    localparam logic [15:0] HI_RESET_DEFAULT  = 16'h7FFF;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/ads1115_i2c_target_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered START/STOP and SCL edge flags.
// A pin change shows up on the flags three clocks later; o_sda is aligned with the flags.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            o_sda      <= 1'b1;
            o_scl_rise <= 1'b0;
            o_scl_fall <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
            o_sda      <= r_sda_sync[1];
            o_scl_rise <= r_scl_sync[1] & ~r_scl_prev;
            o_scl_fall <= ~r_scl_sync[1] & r_scl_prev;
            // SDA may only move while SCL is high for START/STOP
            o_start    <= r_scl_sync[1] & r_scl_prev & ~r_sda_sync[1] & r_sda_prev;
            o_stop     <= r_scl_sync[1] & r_scl_prev & r_sda_sync[1] & ~r_sda_prev;
        end
    end

endmodule

// File: rtl/ads1115_i2c_target.sv
// I2C target emulating the ADS1115 pointer/config/threshold/conversion registers.
// Bits are sampled on SCL rise; SDA drive only changes just after an SCL fall.
module ads1115_i2c_target
    import ads1115_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter logic [15:0] CFG_RESET = CFG_RESET_DEFAULT,
    parameter logic [15:0] LO_RESET  = LO_RESET_DEFAULT,
    parameter logic [15:0] HI_RESET  = HI_RESET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl_in,
    input  logic        i_sda_in,
    output logic        o_sda_oe,
    input  logic [15:0] i_conv_data,
    input  logic        i_conv_valid,
    output logic [15:0] o_cfg_value,
    output logic        o_cfg_wr,
    output logic        o_busy
);

    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic [15:0] w_reg_sel;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_done;
    logic        r_rw;
    logic [1:0]  r_ptr;
    logic [1:0]  r_wr_cnt;
    logic [7:0]  r_wr_msb;
    logic [15:0] r_conv;
    logic [15:0] r_cfg;
    logic [15:0] r_lo;
    logic [15:0] r_hi;
    logic        r_ready;
    logic [15:0] r_shadow;
    logic [7:0]  r_tx;
    logic        r_sent_msb;
    logic        r_master_nack;

    i2c_bus_sync u_bus_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl_in),
        .i_sda      (i_sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign o_cfg_value = r_cfg;

    // Config readback replaces OS with the conversion-ready flag
    always_comb begin
        w_reg_sel = r_conv;
        case (r_ptr)
            PTR_CONV: w_reg_sel = r_conv;
            PTR_CFG:  w_reg_sel = {r_ready, r_cfg[14:0]};
            PTR_LO:   w_reg_sel = r_lo;
            PTR_HI:   w_reg_sel = r_hi;
            default:  w_reg_sel = r_conv;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_byte_done   <= 1'b0;
            r_rw          <= 1'b0;
            r_ptr         <= PTR_CONV;
            r_wr_cnt      <= 2'd0;
            r_wr_msb      <= 8'h00;
            r_conv        <= 16'h0000;
            r_cfg         <= CFG_RESET;
            r_lo          <= LO_RESET;
            r_hi          <= HI_RESET;
            r_ready       <= 1'b1;
            r_shadow      <= 16'h0000;
            r_tx          <= 8'h00;
            r_sent_msb    <= 1'b0;
            r_master_nack <= 1'b0;
            o_sda_oe      <= 1'b0;
            o_cfg_wr      <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_cfg_wr <= 1'b0;
            if (i_conv_valid) begin
                r_conv  <= i_conv_data;
                r_ready <= 1'b1;
            end

            if (w_start) begin
                r_state     <= ST_ADDR;
                o_busy      <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_byte_done <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                o_busy   <= 1'b0;
                o_sda_oe <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA: begin
                        r_shift   <= {r_shift[6:0], w_sda};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
                    end
                    ST_RDATA_ACK: r_master_nack <= w_sda;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    ST_ADDR: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        if (r_shift[7:1] == DEV_ADDR) begin
                            r_state  <= ST_ADDR_ACK;
                            r_rw     <= r_shift[0];
                            o_sda_oe <= 1'b1;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end
                    ST_ADDR_ACK: if (r_rw) begin
                        // Snapshot keeps a two-byte read coherent against conv_valid
                        r_state    <= ST_RDATA;
                        r_shadow   <= w_reg_sel;
                        r_tx       <= w_reg_sel[15:8];
                        r_sent_msb <= 1'b1;
                        o_sda_oe   <= ~w_reg_sel[15];
                    end else begin
                        r_state  <= ST_PTR;
                        o_sda_oe <= 1'b0;
                    end
                    ST_PTR: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        r_ptr       <= r_shift[1:0];
                        r_state     <= ST_PTR_ACK;
                        o_sda_oe    <= 1'b1;
                    end
                    ST_PTR_ACK: begin
                        r_state  <= ST_WDATA;
                        r_wr_cnt <= 2'd0;
                        o_sda_oe <= 1'b0;
                    end
                    ST_WDATA: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        if (r_wr_cnt == 2'd0) begin
                            r_wr_msb <= r_shift;
                            r_wr_cnt <= 2'd1;
                            r_state  <= ST_WDATA_ACK;
                            o_sda_oe <= 1'b1;
                        end else if (r_wr_cnt == 2'd1) begin
                            r_wr_cnt <= 2'd2;
                            r_state  <= ST_WDATA_ACK;
                            o_sda_oe <= 1'b1;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end
                    ST_WDATA_ACK: begin
                        r_state  <= ST_WDATA;
                        o_sda_oe <= 1'b0;
                        // r_shift still holds the LSB; the ACK bit is not shifted in
                        if (r_wr_cnt == 2'd2) begin
                            case (r_ptr)
                                PTR_CFG: begin
                                    r_cfg    <= {r_wr_msb, r_shift};
                                    o_cfg_wr <= 1'b1;
                                    if (r_wr_msb[7]) r_ready <= 1'b0;
                                end
                                PTR_LO:  r_lo <= {r_wr_msb, r_shift};
                                PTR_HI:  r_hi <= {r_wr_msb, r_shift};
                                default: ;
                            endcase
                        end
                    end
                    ST_RDATA: if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        r_state     <= ST_RDATA_ACK;
                        o_sda_oe    <= 1'b0;
                    end else begin
                        r_tx     <= {r_tx[6:0], 1'b0};
                        o_sda_oe <= ~r_tx[6];
                    end
                    ST_RDATA_ACK: if (r_master_nack) begin
                        r_state <= ST_IGNORE;
                    end else begin
                        r_state    <= ST_RDATA;
                        r_sent_msb <= ~r_sent_msb;
                        r_tx       <= r_sent_msb ? r_shadow[7:0] : r_shadow[15:8];
                        o_sda_oe   <= r_sent_msb ? ~r_shadow[7] : ~r_shadow[15];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ads1115_i2c_target.sv
// Bench for ads1115_i2c_target: a bit-banged I2C master with an expected-value queue,
// a table of register write/readback vectors and hand-written corner-case sequences.
module tb_ads1115_i2c_target;

    localparam int Q = 5;

    typedef struct {
        string       name;
        logic [15:0] value;
    } expItem_t;

    typedef struct {
        logic [1:0]  ptr;
        logic [15:0] data;
        logic [15:0] expCfgWr;
        logic [15:0] expCfg;
        logic [15:0] expRead;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sclM;
    logic        sdaM;
    logic        convValid;
    logic [15:0] convData;
    logic        sdaOe;
    logic [15:0] cfgValue;
    logic        cfgWr;
    logic        busy;
    logic        sdaLine;

    expItem_t    scoreQ[$];
    vec_t        vecs[5];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cfgWrPulses = 0;
    int          oeCycles = 0;
    logic [15:0] cfgAtPulse = 16'h0000;

    assign sdaLine = sdaM & ~sdaOe;

    always #5 clk = ~clk;

    ads1115_i2c_target dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_scl_in     (sclM),
        .i_sda_in     (sdaLine),
        .o_sda_oe     (sdaOe),
        .i_conv_data  (convData),
        .i_conv_valid (convValid),
        .o_cfg_value  (cfgValue),
        .o_cfg_wr     (cfgWr),
        .o_busy       (busy)
    );

    // Count cfg_wr pulses and cycles with SDA pulled, away from the active edge
    always @(negedge clk) begin
        if (cfgWr) begin
            cfgWrPulses = cfgWrPulses + 1;
            cfgAtPulse  = cfgValue;
        end
        if (sdaOe) oeCycles = oeCycles + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExpected(input string name, input logic [15:0] value);
        expItem_t e;
        e.name  = name;
        e.value = value;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [15:0] actual);
        expItem_t e;
        checkCount = checkCount + 1;
        if (scoreQ.size() == 0) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL scoreboard-empty actual=%h required=<entry>", actual);
        end else begin
            e = scoreQ.pop_front();
            if (actual !== e.value) begin
                errorCount = errorCount + 1;
                $display("[TB] FAIL %s actual=%h required=%h", e.name, actual, e.value);
            end
        end
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; waitClks(Q);
        sclM = 1'b1; waitClks(Q);
        sdaM = 1'b0; waitClks(Q);
        sclM = 1'b0; waitClks(Q);
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitClks(Q);
        sclM = 1'b1; waitClks(Q);
        sdaM = 1'b1; waitClks(Q);
    endtask

    task automatic driveBit(input logic b);
        sdaM = b;    waitClks(Q);
        sclM = 1'b1; waitClks(2 * Q);
        sclM = 1'b0; waitClks(Q);
    endtask

    task automatic sampleBit(output logic r);
        sdaM = 1'b1; waitClks(Q);
        sclM = 1'b1; waitClks(Q);
        r = sdaLine; waitClks(Q);
        sclM = 1'b0; waitClks(Q);
    endtask

    task automatic sendAndCheck(input string name, input logic [7:0] b, input logic expNack);
        logic ack;
        pushExpected(name, {15'd0, expNack});
        for (int i = 7; i >= 0; i--) driveBit(b[i]);
        sampleBit(ack);
        checkOutput({15'd0, ack});
    endtask

    task automatic readAndCheck(input string name, input logic [7:0] expByte, input logic nack);
        logic [7:0] d;
        pushExpected(name, {8'd0, expByte});
        for (int i = 7; i >= 0; i--) sampleBit(d[i]);
        driveBit(nack);
        checkOutput({8'd0, d});
    endtask

    task automatic setPointer(input logic [1:0] ptr);
        i2cStart();
        sendAndCheck("addr write ack", 8'h90, 1'b0);
        sendAndCheck("pointer ack", {6'd0, ptr}, 1'b0);
    endtask

    task automatic readBack(input logic [1:0] ptr, input logic [15:0] expVal, input int nBytes);
        setPointer(ptr);
        i2cStart();
        sendAndCheck("addr read ack", 8'h91, 1'b0);
        for (int i = 0; i < nBytes; i++)
            readAndCheck("read byte", (i % 2 == 0) ? expVal[15:8] : expVal[7:0], i == nBytes - 1);
        pushExpected("sda released after nack", 16'd0);
        checkOutput({15'd0, sdaOe});
        i2cStop();
    endtask

    task automatic applyStimulus(input vec_t v);
        int pulsesBefore;
        pulsesBefore = cfgWrPulses;
        i2cStart();
        pushExpected("busy after start", 16'd1);
        checkOutput({15'd0, busy});
        sendAndCheck("addr write ack", 8'h90, 1'b0);
        sendAndCheck("pointer ack", {6'd0, v.ptr}, 1'b0);
        sendAndCheck("msb ack", v.data[15:8], 1'b0);
        sendAndCheck("lsb ack", v.data[7:0], 1'b0);
        i2cStop();
        pushExpected("busy after stop", 16'd0);
        checkOutput({15'd0, busy});
        pushExpected("cfg_wr pulses", v.expCfgWr);
        checkOutput(16'(cfgWrPulses - pulsesBefore));
        pushExpected("cfg_value", v.expCfg);
        checkOutput(cfgValue);
        if (v.expCfgWr != 16'd0) begin
            pushExpected("cfg_value at cfg_wr", v.expCfg);
            checkOutput(cfgAtPulse);
        end
        readBack(v.ptr, v.expRead, 2);
    endtask

    initial begin
        int pulsesBefore;
        int oeBefore;

        // ptr, data, cfg_wr pulses, cfg_value, readback (OS bit reflects ready flag)
        vecs[0] = '{2'd1, 16'hC383, 16'd1, 16'hC383, 16'h4383};
        vecs[1] = '{2'd2, 16'h1234, 16'd0, 16'hC383, 16'h1234};
        vecs[2] = '{2'd3, 16'hABCD, 16'd0, 16'hC383, 16'hABCD};
        vecs[3] = '{2'd1, 16'h0583, 16'd1, 16'h0583, 16'h0583};
        vecs[4] = '{2'd0, 16'h5555, 16'd0, 16'h0583, 16'h0000};

        rstN = 1'b0; sclM = 1'b1; sdaM = 1'b1; convValid = 1'b0; convData = 16'h0000;
        waitClks(5);
        rstN = 1'b1;
        waitClks(2);
        pushExpected("reset sda_oe", 16'd0);     checkOutput({15'd0, sdaOe});
        pushExpected("reset cfg_wr", 16'd0);     checkOutput({15'd0, cfgWr});
        pushExpected("reset busy", 16'd0);       checkOutput({15'd0, busy});
        pushExpected("reset cfg_value", 16'h8583); checkOutput(cfgValue);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // New sample sets the ready flag so OS reads back as 1
        convData = 16'h1234; convValid = 1'b1;
        waitClks(1);
        convValid = 1'b0;
        readBack(2'd1, 16'h8583, 2);
        readBack(2'd0, 16'h1234, 2);

        $display("[TB] wrong address transfer");
        pulsesBefore = cfgWrPulses;
        oeBefore = oeCycles;
        i2cStart();
        sendAndCheck("wrong addr nack", 8'h92, 1'b1);
        sendAndCheck("ignored pointer", 8'h01, 1'b1);
        sendAndCheck("ignored data", 8'hFF, 1'b1);
        i2cStop();
        pushExpected("sda_oe never driven", 16'd0); checkOutput(16'(oeCycles - oeBefore));
        pushExpected("no cfg_wr", 16'd0);           checkOutput(16'(cfgWrPulses - pulsesBefore));
        readBack(2'd1, 16'h8583, 2);

        $display("[TB] third data byte");
        i2cStart();
        sendAndCheck("addr write ack", 8'h90, 1'b0);
        sendAndCheck("pointer ack", 8'h03, 1'b0);
        sendAndCheck("byte1 ack", 8'h11, 1'b0);
        sendAndCheck("byte2 ack", 8'h22, 1'b0);
        sendAndCheck("byte3 nack", 8'h33, 1'b1);
        i2cStop();
        readBack(2'd3, 16'h1122, 2);

        $display("[TB] reset during read");
        setPointer(2'd0);
        i2cStart();
        sendAndCheck("addr read ack", 8'h91, 1'b0);
        pushExpected("driving msb bit 0", 16'd1);
        checkOutput({15'd0, sdaOe});
        rstN = 1'b0;
        @(posedge clk);
        #1;
        pushExpected("sda released by reset", 16'd0);
        checkOutput({15'd0, sdaOe});
        waitClks(2);
        pushExpected("cfg_value after reset", 16'h8583); checkOutput(cfgValue);
        pushExpected("busy after reset", 16'd0);         checkOutput({15'd0, busy});
        rstN = 1'b1;
        waitClks(4);
        i2cStop();
        readBack(2'd2, 16'h8000, 4);
        readBack(2'd3, 16'h7FFF, 2);
        readBack(2'd0, 16'h0000, 2);
        readBack(2'd1, 16'h8583, 2);

        pushExpected("scoreboard drained", 16'd0);
        checkOutput(16'(scoreQ.size() - 1));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
